// File: rtl/demux_fifo2_pkg.sv
// demux_pkg: shared defaults, word type and route-select encoding for demux_fifo2.
package demux_pkg;
    localparam int WIDTH_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 4;
    typedef logic [15:0] word_t;
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/demux_fifo2_sync_fifo.sv
// sync_fifo: single-clock FIFO with level-derived full/empty and a zeroed head when empty.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full  = level_q == FULL_LVL;
    assign empty = level_q == '0;
    assign level = level_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = (do_push && !do_pop) ? level_q + 1'b1 :
                   (do_pop && !do_push) ? level_q - 1'b1 : level_q;
    end

    // Storage needs no reset: head is masked to zero whenever the level is 0.
    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

// File: rtl/demux_fifo2.sv
// demux_fifo2: 1-to-2 word demux with a FIFO and independent handshake per output.
// Define DEMUX_FIFO2_COUNT_EN to add per-output pop counters cnt_a/cnt_b.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_a_data,
    output logic                   out_a_valid,
    input  logic                   out_a_ready,
    output logic [WIDTH-1:0]       out_b_data,
    output logic                   out_b_valid,
    input  logic                   out_b_ready,
    output logic [$clog2(DEPTH):0] level_a,
    output logic [$clog2(DEPTH):0] level_b
`ifdef DEMUX_FIFO2_COUNT_EN
    ,
    output logic [15:0]            cnt_a,
    output logic [15:0]            cnt_b
`endif
);
    logic full_a, full_b, empty_a, empty_b, push_a, push_b;

    // Ready looks only at the selected FIFO's full flag, never at consumer ready.
    assign in_ready    = (in_sel == SEL_A) ? !full_a : !full_b;
    assign push_a      = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b      = in_valid && in_ready && (in_sel == SEL_B);
    assign out_a_valid = !empty_a;
    assign out_b_valid = !empty_b;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push(push_a), .wdata(in_data), .pop(out_a_ready),
        .full(full_a), .empty(empty_a), .level(level_a), .head(out_a_data)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .wdata(in_data), .pop(out_b_ready),
        .full(full_b), .empty(empty_b), .level(level_b), .head(out_b_data)
    );

`ifdef DEMUX_FIFO2_COUNT_EN
    word_t cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

    always_comb begin
        cnt_a_d = (out_a_valid && out_a_ready) ? cnt_a_q + 1'b1 : cnt_a_q;
        cnt_b_d = (out_b_valid && out_b_ready) ? cnt_b_q + 1'b1 : cnt_b_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end
`endif
endmodule

// File: tb/tb_demux_fifo2.sv
// tb_demux_fifo2: scoreboard bench; queues per output model expected order, levels and ready.
module tb_demux_fifo2;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 0;
    logic             rst_n = 0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sel = 0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [WIDTH-1:0] out_a_data, out_b_data;
    logic             out_a_valid, out_b_valid;
    logic             out_a_ready = 0;
    logic             out_b_ready = 0;
    logic [2:0]       level_a, level_b;
`ifdef DEMUX_FIFO2_COUNT_EN
    logic [15:0]      cnt_a, cnt_b;
`endif

    int checks = 0;
    int failures = 0;
    bit mon_en = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] cnt_a_m = 0;
    logic [15:0] cnt_b_m = 0;

    demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_a_data(out_a_data), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_b_data(out_b_data), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
        .level_a(level_a), .level_b(level_b)
`ifdef DEMUX_FIFO2_COUNT_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes seen at a falling edge happen at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            cnt_a_m = 0;
            cnt_b_m = 0;
        end else if (mon_en) begin
            check("level_a", level_a, qa.size());
            check("level_b", level_b, qb.size());
            check("valid_a", out_a_valid, qa.size() != 0);
            check("valid_b", out_b_valid, qb.size() != 0);
            if (qa.size() == 0) check("idle_data_a", out_a_data, 0);
            if (qb.size() == 0) check("idle_data_b", out_b_data, 0);
            check("in_ready", in_ready, in_sel ? qa.size() < DEPTH : qb.size() < DEPTH);
`ifdef DEMUX_FIFO2_COUNT_EN
            check("cnt_a", cnt_a, cnt_a_m);
            check("cnt_b", cnt_b, cnt_b_m);
`endif
            if (out_a_valid && out_a_ready && qa.size() != 0) begin
                check("data_a", out_a_data, qa.pop_front());
                cnt_a_m++;
            end
            if (out_b_valid && out_b_ready && qb.size() != 0) begin
                check("data_b", out_b_data, qb.pop_front());
                cnt_b_m++;
            end
            if (in_valid && in_ready) begin
                if (in_sel) qa.push_back(in_data);
                else qb.push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sel, input logic [15:0] d);
        int n = 0;
        in_sel = sel;
        in_data = d;
        in_valid = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        check("send_accepted", in_ready, 1);
        step();
        in_valid = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        rst_n = 1;
        mon_en = 1;
        @(negedge clk);
        check("rst_valid_a", out_a_valid, 0);
        check("rst_valid_b", out_b_valid, 0);
        check("rst_level_a", level_a, 0);
        check("rst_level_b", level_b, 0);
        check("rst_data_a", out_a_data, 0);
        check("rst_data_b", out_b_data, 0);
        in_sel = 1;
        #1 check("rst_ready_sel1", in_ready, 1);
        in_sel = 0;
        #1 check("rst_ready_sel0", in_ready, 1);
        step();

        out_a_ready = 1;
        out_b_ready = 1;
        send(1, 16'h1234);
        send(0, 16'hABCD);
        repeat (3) step();
        @(negedge clk);
        check("drain_level_a", level_a, 0);
        check("drain_level_b", level_b, 0);
        step();

        out_a_ready = 0;
        for (int i = 1; i <= 4; i++) send(1, 16'(i));
        @(negedge clk);
        check("full_level_a", level_a, 4);
        in_sel = 1;
        #1 check("full_ready_sel1", in_ready, 0);
        in_sel = 0;
        #1 check("full_ready_sel0", in_ready, 1);
        step();
        in_sel = 1;
        in_data = 16'h0005;
        in_valid = 1;
        repeat (2) step();
        @(negedge clk);
        check("held_level_a", level_a, 4);
        step();
        out_a_ready = 1;
        @(negedge clk);
        check("full_pop_ready", in_ready, 0);
        step();
        @(negedge clk);
        check("pop_refused_level_a", level_a, 3);
        check("pop_refused_ready", in_ready, 1);
        step();
        in_valid = 0;
        repeat (6) step();

        out_b_ready = 0;
        send(0, 16'hB001);
        send(0, 16'hB002);
        send(0, 16'hB003);
        @(negedge clk);
        check("fill_level_b", level_b, 3);
        step();
        in_sel = 0;
        in_data = 16'hBEEF;
        in_valid = 1;
        rst_n = 0;
        step();
        rst_n = 1;
        in_valid = 0;
        @(negedge clk);
        check("rstmid_level_b", level_b, 0);
        check("rstmid_valid_b", out_b_valid, 0);
        check("rstmid_data_b", out_b_data, 0);
        step();
        out_b_ready = 1;
        repeat (3) step();

`ifdef DEMUX_FIFO2_COUNT_EN
        send(0, 16'hC001);
        send(0, 16'hC002);
        in_sel = 1;
        in_valid = 1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 16'(i);
            step();
        end
        in_valid = 0;
        repeat (3) step();
        @(negedge clk);
        check("cnt_a_max", cnt_a, 16'hFFFF);
        check("cnt_b_hold", cnt_b, 2);
        step();
        send(1, 16'h5555);
        repeat (3) step();
        @(negedge clk);
        check("cnt_a_wrap", cnt_a, 16'h0000);
        check("cnt_b_after_wrap", cnt_b, 2);
        step();
`endif

        check("sb_empty_a", qa.size(), 0);
        check("sb_empty_b", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_fifo2.md
Name: demux_fifo2

Overview:
- 1-to-2 demultiplexer for the 16-bit datapath: the inverse of the 2:1 word mux.
- Steers each accepted input word to output A or output B.
- Each output has a small FIFO and an independent valid/ready handshake, so one slow consumer does not stall traffic bound for the other.
- Sits between a single producer (ALU/register-file result bus) and two downstream consumers.

Parameters:
- WIDTH, 16: data word width.
- DEPTH, 4: entries per output FIFO; must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  route select: 1 → output A, 0 → output B (same polarity as the word mux).
- in_valid  input  1  producer has a word.
- in_ready  output  1  selected FIFO can accept.
- out_a_data  output  WIDTH  head of FIFO A.
- out_a_valid  output  1  FIFO A non-empty.
- out_a_ready  input  1  consumer A takes the head.
- out_b_data  output  WIDTH  head of FIFO B.
- out_b_valid  output  1  FIFO B non-empty.
- out_b_ready  input  1  consumer B takes the head.
- level_a  output  $clog2(DEPTH)+1  FIFO A occupancy.
- level_b  output  $clog2(DEPTH)+1  FIFO B occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge): both FIFOs empty; pointers and levels 0; out_*_valid=0; out_*_data=0.
  - Reset overrides any push or pop in the same cycle.
  - A word mid-handshake is discarded.
- in_ready is combinational: in_sel ? !full_a : !full_b. It never depends on out_*_ready, so there is no input-to-output comb path.
- Push: in_valid && in_ready at an edge writes in_data into the selected FIFO.
  - in_sel is sampled only when that handshake occurs.
- Latency: a word pushed at edge N is visible on out_x_data with out_x_valid=1 after edge N. No same-cycle bypass.
- Pop: out_x_valid && out_x_ready at an edge advances FIFO x head.
  - out_x_ready while empty has no effect.
- Output stability: out_x_data shows the head entry while valid. When the FIFO is empty it is driven to 0, never stale RAM.
- Simultaneous push and pop on the same FIFO:
  - Level is unchanged and both pointers advance.
  - When full, in_ready is still 0, so the push is refused even though a pop happens that cycle (conservative; no comb path).
  - When empty, the pop is a no-op and the push lands.
- Both FIFOs can pop in the same cycle. At most one push per cycle, since there is one input.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Full/empty derive from level: full when level==DEPTH, empty when level==0.
- Ordering: FIFO order within each output. No ordering guarantee across A vs B.
- in_valid while in_ready=0: no state change. The producer must hold in_data/in_sel until accepted.

Optional Feature:
- Macro: DEMUX_FIFO2_COUNT_EN.
- With the macro defined, two extra outputs are added:
  - cnt_a: 16-bit count of words popped from A.
  - cnt_b: 16-bit count of words popped from B.
  - Both are reset to 0, increment by 1 per pop handshake, and wrap 0xFFFF→0x0000.
- Without it: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - WIDTH_DEFAULT=16.
  - DEPTH_DEFAULT=4.
  - typedef word_t (logic [15:0]).
  - Route-select constants SEL_A=1'b1, SEL_B=1'b0.
- Sub-module sync_fifo: one parameterised FIFO holding storage, pointers and level, with outputs full/empty/level/head.
  - Instantiated twice.
  - Top level holds only the steering and ready logic, plus the optional counters.

Test Plan:
- Reset then idle → out_a_valid=0, out_b_valid=0, levels 0, out_*_data=0x0000, in_ready=1 for either in_sel.
- Push 0x1234 with sel=1 and 0xABCD with sel=0 on consecutive cycles, consumers ready → 0x1234 on A one cycle after its push, 0xABCD on B one cycle after its push; levels return to 0.
- out_a_ready=0; push 0x0001..0x0004 to A → level_a=4, in_ready=0 for sel=1 but 1 for sel=0; a 5th push to A is held. Raise out_a_ready → pops return 0x0001,0x0002,0x0003,0x0004 in order, then the held word is accepted.
- A full (level 4) with out_a_ready=1 and in_valid=1, sel=1 in the same cycle → pop occurs, push refused, level_a=3 next cycle.
- Fill B with 3 words, pulse rst_n=0 for one cycle while pushing → level_b=0, out_b_valid=0, the pushed word is lost.
- With DEMUX_FIFO2_COUNT_EN: preload cnt_a via 65535 pops, then 1 more → cnt_a=0x0000; cnt_b unaffected.
